display_update_arbiter: RTL and testbench



---
 rtl/vga_pkg.sv | 15 +
 rtl/display_update_arbiter_if.sv | 30 +++
 rtl/display_update_arbiter_rr_arbiter.sv | 30 +++
 rtl/display_update_arbiter.sv | 106 ++++++++++
 tb/tb_display_update_arbiter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Row timing constants shared by the vga counter and the display update arbiter,
// plus the arbiter's FSM state type.
package vga_pkg;

    localparam logic [9:0]  VBLANK_ROW = 10'd480;
    localparam logic [9:0]  CLOSE_ROW  = 10'd518;
    localparam logic [9:0]  LAST_ROW   = 10'd520;
    localparam int unsigned COL_PERIOD = 1600;

    typedef enum logic {
        WAIT,
        GRANT
    } upd_state_t;

endpackage

// File: rtl/display_update_arbiter_if.sv
// Requester-side handshake bundle: level requests with slot/value payloads, grant pulses back.
interface display_update_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int SLOT_W  = 3,
    parameter int VALUE_W = 3
) ();

    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*SLOT_W-1:0]  req_slot;
    logic [NUM_REQ*VALUE_W-1:0] req_value;
    logic [NUM_REQ-1:0]         ack;
    logic                       bad_slot;

    modport master (
        output req,
        output req_slot,
        output req_value,
        input  ack,
        input  bad_slot
    );

    modport slave (
        input  req,
        input  req_slot,
        input  req_value,
        output ack,
        output bad_slot
    );

endinterface

// File: rtl/display_update_arbiter_rr_arbiter.sv
// Combinational round-robin select: first eligible index at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     eligible,
    input  logic [PTR_W-1:0] pointer,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] winner,
    output logic             valid
);

    int unsigned idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (int'(pointer) + i) % N;
            if (!valid && eligible[idx]) begin
                valid      = 1'b1;
                grant[idx] = 1'b1;
                winner     = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/display_update_arbiter.sv
// Commits requester writes into the digit slot file only during vertical blank,
// one round-robin grant per cycle, and counts vblank windows.
module display_update_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int NUM_SLOTS = 5,
    parameter int VALUE_W   = 3,
    parameter int SLOT_W    = 3
) (
    input  logic                         clk_50,
    input  logic                         reset,
    input  logic [9:0]                   row,
    display_update_arbiter_if.slave      bus,
    output logic [NUM_SLOTS*VALUE_W-1:0] slot_values,
    output logic [15:0]                  frame_count,
    output logic                         in_window
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    upd_state_t         state;
    logic               vb_d;
    logic [PTR_W-1:0]   pointer;
    logic [NUM_REQ-1:0] ack_q;
    logic               bad_q;

    logic               vb;
    logic               close_now;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   winner;
    logic               any_grant;
    logic [SLOT_W-1:0]  win_slot;
    logic [VALUE_W-1:0] win_value;
    logic [PTR_W-1:0]   pointer_next;

    assign bus.ack      = ack_q;
    assign bus.bad_slot = bad_q;

    always_comb begin
        vb           = (row >= VBLANK_ROW);
        close_now    = (row >= CLOSE_ROW) || !vb;
        // Masking by the live ack keeps a still-held req from winning twice in a row.
        eligible     = bus.req & ~ack_q;
        win_slot     = bus.req_slot[int'(winner)*SLOT_W +: SLOT_W];
        win_value    = bus.req_value[int'(winner)*VALUE_W +: VALUE_W];
        pointer_next = PTR_W'((int'(winner) + 1) % NUM_REQ);
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .eligible (eligible),
        .pointer  (pointer),
        .grant    (grant),
        .winner   (winner),
        .valid    (any_grant)
    );

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state       <= WAIT;
            vb_d        <= 1'b1;
            pointer     <= '0;
            ack_q       <= '0;
            bad_q       <= 1'b0;
            slot_values <= '0;
            frame_count <= '0;
            in_window   <= 1'b0;
        end else begin
            vb_d  <= vb;
            ack_q <= '0;
            bad_q <= 1'b0;
            unique case (state)
                WAIT: begin
                    if (vb && !vb_d) begin
                        state       <= GRANT;
                        in_window   <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                    end
                end
                GRANT: begin
                    if (close_now) begin
                        state     <= WAIT;
                        in_window <= 1'b0;
                    end else if (any_grant) begin
                        ack_q   <= grant;
                        pointer <= pointer_next;
                        if (int'(win_slot) < NUM_SLOTS) begin
                            slot_values[int'(win_slot)*VALUE_W +: VALUE_W] <= win_value;
                        end else begin
                            bad_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= WAIT;
                    in_window <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_update_arbiter.sv
// Directed bench: a cycle-by-cycle vector table plus hand-written reset, contention and wrap sequences.
module tb_display_update_arbiter;

    logic        clk_50 = 1'b0;
    logic        reset;
    logic [9:0]  row;
    logic [14:0] slot_values;
    logic [15:0] frame_count;
    logic        in_window;

    int checks = 0;
    int errors = 0;

    display_update_arbiter_if #(.NUM_REQ(2), .SLOT_W(3), .VALUE_W(3)) bus ();

    display_update_arbiter #(
        .NUM_REQ   (2),
        .NUM_SLOTS (5),
        .VALUE_W   (3),
        .SLOT_W    (3)
    ) dut (
        .clk_50      (clk_50),
        .reset       (reset),
        .row         (row),
        .bus         (bus),
        .slot_values (slot_values),
        .frame_count (frame_count),
        .in_window   (in_window)
    );

    always #5 clk_50 = ~clk_50;

    typedef struct {
        logic [9:0]  row;
        logic [1:0]  req;
        logic [5:0]  slot;
        logic [5:0]  value;
        logic [1:0]  ack;
        logic        bad;
        logic        win;
        logic [14:0] slots;
        logic [15:0] fc;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50);
        #1;
    endtask

    task automatic drive(input logic [9:0] r, input logic [1:0] rq, input logic [5:0] s, input logic [5:0] v);
        row           = r;
        bus.req       = rq;
        bus.req_slot  = s;
        bus.req_value = v;
    endtask

    task automatic chk_all(input string tag, input logic [1:0] a, input logic b, input logic w,
                           input logic [14:0] sv, input logic [15:0] fc);
        chk({tag, " ack"},         32'(bus.ack),      32'(a));
        chk({tag, " bad_slot"},    32'(bus.bad_slot), 32'(b));
        chk({tag, " in_window"},   32'(in_window),    32'(w));
        chk({tag, " slot_values"}, 32'(slot_values),  32'(sv));
        chk({tag, " frame_count"}, 32'(frame_count),  32'(fc));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // row, req, slot{1,0}, value{1,0} -> ack, bad, in_window, slot_values, frame_count
        vecs[0]  = '{10'd100, 2'b00, 6'o00, 6'o00, 2'b00, 1'b0, 1'b0, 15'h0000, 16'd0};
        vecs[1]  = '{10'd100, 2'b01, 6'o02, 6'o05, 2'b00, 1'b0, 1'b0, 15'h0000, 16'd0};
        vecs[2]  = '{10'd479, 2'b01, 6'o02, 6'o05, 2'b00, 1'b0, 1'b0, 15'h0000, 16'd0};
        vecs[3]  = '{10'd480, 2'b01, 6'o02, 6'o05, 2'b00, 1'b0, 1'b1, 15'h0000, 16'd1};
        vecs[4]  = '{10'd480, 2'b01, 6'o02, 6'o05, 2'b01, 1'b0, 1'b1, 15'h0140, 16'd1};
        vecs[5]  = '{10'd481, 2'b00, 6'o00, 6'o00, 2'b00, 1'b0, 1'b1, 15'h0140, 16'd1};
        vecs[6]  = '{10'd481, 2'b11, 6'o10, 6'o43, 2'b10, 1'b0, 1'b1, 15'h0160, 16'd1};
        vecs[7]  = '{10'd481, 2'b11, 6'o10, 6'o43, 2'b01, 1'b0, 1'b1, 15'h0163, 16'd1};
        vecs[8]  = '{10'd481, 2'b00, 6'o00, 6'o00, 2'b00, 1'b0, 1'b1, 15'h0163, 16'd1};
        vecs[9]  = '{10'd482, 2'b10, 6'o60, 6'o70, 2'b10, 1'b1, 1'b1, 15'h0163, 16'd1};
        vecs[10] = '{10'd482, 2'b00, 6'o00, 6'o00, 2'b00, 1'b0, 1'b1, 15'h0163, 16'd1};
        vecs[11] = '{10'd518, 2'b01, 6'o04, 6'o06, 2'b00, 1'b0, 1'b0, 15'h0163, 16'd1};
        vecs[12] = '{10'd519, 2'b01, 6'o04, 6'o06, 2'b00, 1'b0, 1'b0, 15'h0163, 16'd1};
        vecs[13] = '{10'd520, 2'b01, 6'o04, 6'o06, 2'b00, 1'b0, 1'b0, 15'h0163, 16'd1};
        vecs[14] = '{10'd0,   2'b01, 6'o04, 6'o06, 2'b00, 1'b0, 1'b0, 15'h0163, 16'd1};
        vecs[15] = '{10'd480, 2'b01, 6'o04, 6'o06, 2'b00, 1'b0, 1'b1, 15'h0163, 16'd2};
        vecs[16] = '{10'd480, 2'b01, 6'o04, 6'o06, 2'b01, 1'b0, 1'b1, 15'h6163, 16'd2};
        vecs[17] = '{10'd490, 2'b00, 6'o00, 6'o00, 2'b00, 1'b0, 1'b1, 15'h6163, 16'd2};
        vecs[18] = '{10'd490, 2'b11, 6'o30, 6'o12, 2'b10, 1'b0, 1'b1, 15'h6363, 16'd2};
        vecs[19] = '{10'd490, 2'b11, 6'o30, 6'o12, 2'b01, 1'b0, 1'b1, 15'h6362, 16'd2};
        vecs[20] = '{10'd0,   2'b00, 6'o00, 6'o00, 2'b00, 1'b0, 1'b0, 15'h6362, 16'd2};

        reset = 1'b1;
        drive(10'd490, 2'b00, 6'o00, 6'o00);
        step();
        step();
        chk_all("reset", 2'b00, 1'b0, 1'b0, 15'h0000, 16'd0);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].row, vecs[i].req, vecs[i].slot, vecs[i].value);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].ack, vecs[i].bad, vecs[i].win,
                    vecs[i].slots, vecs[i].fc);
        end

        // Reset pulse mid-window with req0 pending: blank must stay closed afterwards.
        drive(10'd480, 2'b00, 6'o00, 6'o00);
        step();
        chk_all("rst_pre_open", 2'b00, 1'b0, 1'b1, 15'h6362, 16'd3);
        drive(10'd490, 2'b01, 6'o01, 6'o07);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_all("rst_mid", 2'b00, 1'b0, 1'b0, 15'h0000, 16'd0);
        for (int r = 491; r <= 520; r += 3) begin
            row = 10'(r);
            step();
            chk_all($sformatf("rst_blank_row%0d", r), 2'b00, 1'b0, 1'b0, 15'h0000, 16'd0);
        end
        row = 10'd0;
        step();
        row = 10'd480;
        step();
        chk_all("rst_reopen", 2'b00, 1'b0, 1'b1, 15'h0000, 16'd1);
        step();
        chk_all("rst_grant", 2'b01, 1'b0, 1'b1, 15'h0038, 16'd1);

        // Pointer now at 1: requester 1 goes first.
        drive(10'd490, 2'b11, 6'o10, 6'o43);
        step();
        chk_all("ptr1_first", 2'b10, 1'b0, 1'b1, 15'h0020, 16'd1);
        step();
        chk_all("ptr1_second", 2'b01, 1'b0, 1'b1, 15'h0023, 16'd1);

        // Fresh reset, contention from window open with pointer 0, two frames running.
        drive(10'd100, 2'b00, 6'o00, 6'o00);
        reset = 1'b1;
        step();
        reset = 1'b0;
        row = 10'd479;
        step();
        drive(10'd480, 2'b11, 6'o10, 6'o43);
        step();
        chk_all("cont_open", 2'b00, 1'b0, 1'b1, 15'h0000, 16'd1);
        step();
        chk_all("cont_f1_first", 2'b01, 1'b0, 1'b1, 15'h0003, 16'd1);
        step();
        chk_all("cont_f1_second", 2'b10, 1'b0, 1'b1, 15'h0023, 16'd1);
        drive(10'd0, 2'b00, 6'o00, 6'o00);
        step();
        chk_all("cont_close", 2'b00, 1'b0, 1'b0, 15'h0023, 16'd1);
        drive(10'd480, 2'b11, 6'o10, 6'o65);
        step();
        chk_all("cont_f2_open", 2'b00, 1'b0, 1'b1, 15'h0023, 16'd2);
        step();
        chk_all("cont_f2_first", 2'b01, 1'b0, 1'b1, 15'h0025, 16'd2);
        step();
        chk_all("cont_f2_second", 2'b10, 1'b0, 1'b1, 15'h0035, 16'd2);

        // Frame counter wrap: preload 0xFFFF outside the window, then open one.
        drive(10'd0, 2'b00, 6'o00, 6'o00);
        step();
        force dut.frame_count = 16'hFFFF;
        step();
        release dut.frame_count;
        row = 10'd480;
        step();
        chk("wrap frame_count", 32'(frame_count), 32'h0000);
        chk("wrap in_window", 32'(in_window), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
